// File: rtl/mmio_store_checker_pkg.sv
// Shared types for the MIPS store checker: verdict states, status word layout and
// the store record carried through the capture FIFO.
package mmio_check_pkg;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    PASS = 2'd1,
    FAIL = 2'd2
  } check_state_t;

  localparam int unsigned DONE_BIT    = 0;
  localparam int unsigned PASS_BIT    = 1;
  localparam int unsigned TIMEOUT_BIT = 2;
  localparam int unsigned DROP_LSB    = 8;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } store_rec_t;

  function automatic logic [31:0] status_word(input logic       done,
                                              input logic       pass,
                                              input logic       timeout,
                                              input logic [7:0] drop);
    logic [31:0] w;
    w                = '0;
    w[DONE_BIT]      = done;
    w[PASS_BIT]      = pass;
    w[TIMEOUT_BIT]   = timeout;
    w[DROP_LSB +: 8] = drop;
    return w;
  endfunction

endpackage

// File: rtl/mmio_store_checker_if.sv
// Processor data-memory bus plus the host-side capture stream of the store checker.
interface mmio_store_checker_if;
  logic        memwrite;
  logic [31:0] dataadr;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        cap_valid;
  logic        cap_ready;
  logic [31:0] cap_addr;
  logic [31:0] cap_data;

  modport master (
    output memwrite, dataadr, writedata, cap_ready,
    input  readdata, cap_valid, cap_addr, cap_data
  );

  modport slave (
    input  memwrite, dataadr, writedata, cap_ready,
    output readdata, cap_valid, cap_addr, cap_data
  );
endinterface

// File: rtl/mmio_store_checker_store_fifo.sv
// First-word-fall-through FIFO of store records; head reads zero while empty.
module store_fifo
  import mmio_check_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic       pop,
  input  store_rec_t wr_rec,
  output store_rec_t head,
  output logic       full,
  output logic       empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  store_rec_t      mem [DEPTH];
  logic [AW:0]     wr_ptr;
  logic [AW:0]     rd_ptr;
  logic            push_en;
  logic            pop_en;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // A pop frees the slot the same edge, so push into a full FIFO succeeds alongside it.
  assign pop_en  = pop && !empty;
  assign push_en = push && (!full || pop_en);

  assign head = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop_en)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_en) mem[wr_ptr[AW-1:0]] <= wr_rec;
  end

endmodule

// File: rtl/mmio_store_checker.sv
// Hardware PASS/FAIL judge for MIPS integrity programs with store capture FIFO.
// Optional watchdog enabled by defining MMIO_STORE_CHECKER_TIMEOUT_EN.
module mmio_store_checker
  import mmio_check_pkg::*;
#(
  parameter logic [31:0] RESULT_ADDR    = 32'd84,
  parameter logic [31:0] SCRATCH_ADDR   = 32'd80,
  parameter logic [31:0] EXPECT_DATA    = 32'd7,
  parameter logic [31:0] STATUS_ADDR    = 32'd88,
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input  logic                  clk,
  input  logic                  reset,
  mmio_store_checker_if.slave   bus,
  output logic                  done,
  output logic                  pass,
  output logic [7:0]            drop_cnt
);

  if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two in 2..16");
  end
  if (TIMEOUT_CYCLES == 0 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must fit the 16-bit watchdog");
  end

  check_state_t state;
  check_state_t state_next;
  logic         timeout_flag;
  logic         timeout_next;
  logic         timeout_hit;

  store_rec_t   in_rec;
  store_rec_t   head;
  logic         fifo_full;
  logic         fifo_empty;
  logic         pop_req;
  logic         drop;

`ifdef MMIO_STORE_CHECKER_TIMEOUT_EN
  logic [15:0]  run_cnt;

  always_ff @(posedge clk) begin
    if (reset)             run_cnt <= '0;
    else if (state == RUN) run_cnt <= run_cnt + 16'd1;
  end

  assign timeout_hit = ({16'd0, run_cnt} >= TIMEOUT_CYCLES);
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= RUN;
      timeout_flag <= 1'b0;
    end else begin
      state        <= state_next;
      timeout_flag <= timeout_next;
    end
  end

  // A deciding store wins over a watchdog expiry in the same cycle.
  always_comb begin
    state_next   = state;
    timeout_next = timeout_flag;
    if (state == RUN) begin
      if (bus.memwrite) begin
        if (bus.dataadr == RESULT_ADDR)
          state_next = (bus.writedata == EXPECT_DATA) ? PASS : FAIL;
        else if (bus.dataadr != SCRATCH_ADDR)
          state_next = FAIL;
      end
      if (state_next == RUN && timeout_hit) begin
        state_next   = FAIL;
        timeout_next = 1'b1;
      end
    end
  end

  assign done = (state != RUN);
  assign pass = (state == PASS);

  assign in_rec        = '{addr: bus.dataadr, data: bus.writedata};
  assign bus.cap_valid = !fifo_empty;
  assign bus.cap_addr  = head.addr;
  assign bus.cap_data  = head.data;
  assign pop_req       = bus.cap_valid && bus.cap_ready;
  assign drop          = bus.memwrite && fifo_full && !pop_req;

  store_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .push   (bus.memwrite),
    .pop    (pop_req),
    .wr_rec (in_rec),
    .head   (head),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (reset)                          drop_cnt <= '0;
    else if (drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
  end

  assign bus.readdata = (bus.dataadr == STATUS_ADDR)
                      ? status_word(done, pass, timeout_flag, drop_cnt)
                      : '0;

endmodule

// File: tb/tb_mmio_store_checker.sv
// Randomized and directed bench for mmio_store_checker against a transaction-level model.
module tb_mmio_store_checker;

  localparam int unsigned DEPTH = 4;
`ifdef MMIO_STORE_CHECKER_TIMEOUT_EN
  localparam int unsigned TO = 50;
`else
  localparam int unsigned TO = 1000;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       done;
  logic       pass;
  logic [7:0] drop_cnt;

  mmio_store_checker_if bus();

  mmio_store_checker #(
    .RESULT_ADDR    (32'd84),
    .SCRATCH_ADDR   (32'd80),
    .EXPECT_DATA    (32'd7),
    .STATUS_ADDR    (32'd88),
    .FIFO_DEPTH     (DEPTH),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .done     (done),
    .pass     (pass),
    .drop_cnt (drop_cnt)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: verdict flags, queue of captured stores, counters.
  logic [63:0] q[$];
  bit          m_valid = 0;
  bit          m_rst   = 0;
  bit          m_done, m_pass, m_tmo;
  int          m_drop;
  int          m_run;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_status();
    return (32'(m_drop) << 8) + (32'(m_tmo) << 2) + (32'(m_pass) << 1) + 32'(m_done);
  endfunction

  task automatic model_edge(input logic rs, input logic mw, input logic [31:0] a,
                            input logic [31:0] d, input logic rdy);
    if (rs) begin
      q.delete();
      m_done = 0; m_pass = 0; m_tmo = 0; m_drop = 0; m_run = 0;
      m_rst = 1; m_valid = 1;
    end else begin
      m_rst = 0;
      if (rdy && q.size() > 0) void'(q.pop_front());
      if (mw) begin
        if (q.size() < DEPTH) q.push_back({a, d});
        else if (m_drop < 255) m_drop++;
      end
      if (!m_done) begin
        if (mw && a == 32'd84) begin
          m_done = 1; m_pass = (d == 32'd7);
        end else if (mw && a != 32'd80) begin
          m_done = 1;
        end
`ifdef MMIO_STORE_CHECKER_TIMEOUT_EN
        else if (m_run >= int'(TO)) begin
          m_done = 1; m_tmo = 1;
        end
`endif
        m_run++;
      end
    end
  endtask

  task automatic step(input logic rs, input logic mw, input logic [31:0] a,
                      input logic [31:0] d, input logic rdy);
    logic [63:0] hd;
    reset         = rs;
    bus.memwrite  = mw;
    bus.dataadr   = a;
    bus.writedata = d;
    bus.cap_ready = rdy;
    #2;
    if (m_valid) begin
      check("done", {31'd0, done}, {31'd0, m_done});
      check("pass", {31'd0, pass}, {31'd0, m_pass});
      check("cap_valid", {31'd0, bus.cap_valid}, {31'd0, q.size() > 0});
      check("drop_cnt", {24'd0, drop_cnt}, 32'(m_drop));
      check("readdata", bus.readdata, (a == 32'd88) ? exp_status() : 32'd0);
      if (q.size() > 0) begin
        hd = q[0];
        check("cap_addr", bus.cap_addr, hd[63:32]);
        check("cap_data", bus.cap_data, hd[31:0]);
      end
      if (m_rst) begin
        check("rst_cap_addr", bus.cap_addr, 32'd0);
        check("rst_cap_data", bus.cap_data, 32'd0);
      end
    end
    @(posedge clk);
    model_edge(rs, mw, a, d, rdy);
    #1;
  endtask

  task automatic idle(input logic rdy);
    step(1'b0, 1'b0, 32'd0, 32'd0, rdy);
  endtask

  initial begin
    logic [31:0] a, d;
    bus.memwrite = 0; bus.dataadr = '0; bus.writedata = '0; bus.cap_ready = 0;

    // PASS path with capture order and status word
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(0, 1, 32'd80, 32'd5, 0);
    step(0, 1, 32'd84, 32'd7, 0);
    check("t1_done", {31'd0, done}, 32'd1);
    check("t1_pass", {31'd0, pass}, 32'd1);
    step(0, 0, 32'd88, 0, 0);
    check("t1_status", bus.readdata, 32'h3);
    check("t1_head_addr", bus.cap_addr, 32'd80);
    step(0, 0, 32'd88, 0, 1);
    check("t1_second_data", bus.cap_data, 32'd7);
    step(0, 0, 32'd92, 0, 1);
    check("t1_other_rd", bus.readdata, 32'd0);

    // Wrong result value, then sticky verdict
    step(1, 0, 0, 0, 1);
    step(0, 1, 32'd84, 32'd6, 1);
    step(0, 1, 32'd84, 32'd7, 1);
    check("t2_done", {31'd0, done}, 32'd1);
    check("t2_sticky_pass", {31'd0, pass}, 32'd0);
    idle(1);

    // Unexpected address, unaligned result address, then mid-run reset
    step(1, 0, 0, 0, 0);
    step(0, 1, 32'd100, 32'd1, 0);
    check("t3_fail", {31'd0, done}, 32'd1);
    step(1, 0, 0, 0, 0);
    check("t3_rst_done", {31'd0, done}, 32'd0);
    check("t3_rst_valid", {31'd0, bus.cap_valid}, 32'd0);
    check("t3_rst_drop", {24'd0, drop_cnt}, 32'd0);
    step(0, 1, 32'd85, 32'd7, 0);
    check("t3_unaligned", {30'd0, pass, done}, 32'd1);

    // Six stores into a 4-deep FIFO, then push+pop while full
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) step(0, 1, 32'd80, 32'(i + 10), 0);
    check("t4_drop2", {24'd0, drop_cnt}, 32'd2);
    step(0, 1, 32'd80, 32'd99, 1);
    check("t4_nodrop", {24'd0, drop_cnt}, 32'd2);
    for (int i = 0; i < 5; i++) idle(1);

    // Saturate drop counter
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 300; i++) step(0, 1, 32'd80, 32'(i), 0);
    check("t5_sat", {24'd0, drop_cnt}, 32'd255);
    for (int i = 0; i < 5; i++) idle(1);

`ifdef MMIO_STORE_CHECKER_TIMEOUT_EN
    // Watchdog: only scratch stores after reset release
    step(1, 0, 0, 0, 1);
    for (int i = 1; i <= 55; i++) begin
      step(0, 1, 32'd80, 32'(i), 1);
      if (i == 50) check("t6_not_yet", {31'd0, done}, 32'd0);
      if (i == 51) check("t6_timeout", {30'd0, pass, done}, 32'd1);
    end
    step(0, 0, 32'd88, 0, 1);
    check("t6_bit2", {31'd0, bus.readdata[2]}, 32'd1);
`endif

    // Randomized traffic
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4: a = 32'd80;
        5, 6:          a = 32'd84;
        7:             a = 32'd88;
        8:             a = 32'd85;
        default:       a = $urandom;
      endcase
      d = ($urandom_range(0, 1) == 0) ? 32'd7 : $urandom;
      step(($urandom_range(0, 39) == 0), 1'($urandom_range(0, 1)), a, d,
           ($urandom_range(0, 9) < 7));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mmio_store_checker.md
Name: mmio_store_checker

Overview:
- Synthesizable responder on the single-cycle MIPS data-memory bus (`dataadr`/`writedata`/`memwrite`). It watches processor stores and decides PASS/FAIL in hardware, using the same rule as the integrity programs: a result store of the expected value passes, a store to any unexpected address fails.
- Captures every store into a small FIFO, drained by a host-side consumer over valid/ready.
- Exposes a read-only status word at a mapped address so the program can poll its own verdict.

Parameters:
- RESULT_ADDR, 32'd84, address whose store decides the verdict
- SCRATCH_ADDR, 32'd80, address stores may hit freely
- EXPECT_DATA, 32'd7, value that must be stored to RESULT_ADDR for PASS
- STATUS_ADDR, 32'd88, read-only status word address
- FIFO_DEPTH, 4, capture FIFO entries; power of two, 2..16
- TIMEOUT_CYCLES, 1000, watchdog limit (optional feature only)

Ports:
- clk, input, 1, system clock
- reset, input, 1, synchronous active-high reset
- memwrite, input, 1, processor store strobe
- dataadr, input, 32, processor data address
- writedata, input, 32, processor store data
- readdata, output, 32, status word when dataadr==STATUS_ADDR, else 0; combinational from registers
- cap_valid, output, 1, FIFO head valid
- cap_ready, input, 1, consumer accepts head
- cap_addr, output, 32, head store address
- cap_data, output, 32, head store data
- done, output, 1, verdict reached
- pass, output, 1, verdict is PASS; only meaningful when done=1
- drop_cnt, output, 8, stores lost to a full FIFO; saturates at 255

Behaviour:
- Reset is synchronous: on the rising edge with reset=1, FSM→RUN, FIFO emptied, drop_cnt=0. Therefore done=0, pass=0, cap_valid=0, cap_addr=0, cap_data=0 while reset is held. Reset mid-operation discards the FIFO contents and the verdict.
- All store sampling happens on the rising edge with memwrite=1 and reset=0.
- FSM states: RUN, PASS, FAIL. PASS and FAIL are sticky; only reset leaves them.
- Transitions from RUN:
  - store to RESULT_ADDR with data==EXPECT_DATA → PASS
  - store to RESULT_ADDR with any other data → FAIL
  - store to SCRATCH_ADDR → stay in RUN
  - store to any other address, including STATUS_ADDR → FAIL
- Verdict latency: done/pass are registered and update 1 cycle after the deciding edge.
- Comparisons use the full 32 bits. The address is not word-aligned before comparing, so address 85 is a FAIL.
- Capture:
  - Every store is pushed into the FIFO in all FSM states, including after the verdict.
  - A push is visible on cap_valid the next cycle.
  - Pop happens on a rising edge when cap_valid && cap_ready.
  - The FIFO is first-word-fall-through; cap_addr/cap_data are stable while cap_valid=1 and cap_ready=0.
- Full FIFO:
  - Push while full with no pop in the same cycle → store dropped, drop_cnt++ (saturating).
  - Simultaneous push and pop when full → both succeed, no drop.
  - Pop when empty is ignored.
- Status word layout: bit0=done, bit1=pass, bits[15:8]=drop_cnt, rest 0.

Optional Feature:
- Macro `MMIO_STORE_CHECKER_TIMEOUT_EN`.
- With it defined:
  - 16-bit cycle counter runs in RUN; reset clears it.
  - Counter reaching TIMEOUT_CYCLES → FAIL, registered like any other verdict.
  - Status bit2 set on a timeout FAIL.
- Without it: no counter, bit2 reads 0, and RUN can persist indefinitely.

Decomposition:
- Package `mmio_check_pkg` holds:
  - typedef `check_state_t` enum {RUN, PASS, FAIL}
  - status bit-position localparams: DONE_BIT=0, PASS_BIT=1, TIMEOUT_BIT=2, DROP_LSB=8
  - typedef `store_rec_t` struct {addr[31:0], data[31:0]}
- Sub-module `store_fifo`: parameterized FWFT FIFO carrying store_rec_t, with push/pop/full/empty. It is the only sub-module.

Test Plan:
- Store 80←5, then 84←7 → done=1, pass=1 one cycle after the 84 store; FIFO yields (80,5) then (84,7); status read = 32'h3.
- Store 84←6 → done=1, pass=0; a later store 84←7 leaves pass=0 (sticky).
- Store 100←1 → FAIL; assert reset for one cycle mid-run → done=0, cap_valid=0, drop_cnt=0 on the following cycle.
- cap_ready=0, six stores to 80 with FIFO_DEPTH=4 → drop_cnt=2, FIFO holds first four in order; in the full-FIFO cycle, push with cap_ready=1 → no drop.
- Read with dataadr=88, memwrite=0 after PASS → readdata=32'h3; other addresses → readdata=0.
- `MMIO_STORE_CHECKER_TIMEOUT_EN`, TIMEOUT_CYCLES=50, only stores to 80 → done=1, pass=0, status bit2=1 at cycle 51 after reset release.
